// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the MIPS_32 unified-memory arbiter.
// Optional grant counters are built when ARB_PERF_EN is defined.
package mips_arb_pkg;

   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM, OWN_DBG} owner_t;
   typedef enum logic [1:0] {S_ARB, S_LOCK, S_REL} state_t;

   localparam int PERF_W = 16;

endpackage

// File: rtl/mips_arb_perf_ctr.sv
// Saturating event counter with a synchronous clear that takes priority over counting.
// Instantiated by mips_mem_arbiter only when ARB_PERF_EN is defined.
module mips_arb_perf_ctr
   import mips_arb_pkg::*;
(
   input  logic              clk1,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [PERF_W-1:0] cnt_o
);

   logic [PERF_W-1:0] cnt_q;
   logic [PERF_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {PERF_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port arbiter sharing one synchronous-read memory between IF, MEM and a debug loader.
// Define ARB_PERF_EN to add perf_clr and three saturating grant counters.
module mips_mem_arbiter
   import mips_arb_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4,
   parameter int MAX_LOCK   = 8
)
(
   input  logic              clk1,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_stall,
   output logic              if_rvalid,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_gnt,
   output logic              mem_stall,
   output logic              mem_rvalid,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic              dbg_lock,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic              lock_err,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [1:0]        arb_state
`ifdef ARB_PERF_EN
   ,
   input  logic              perf_clr,
   output logic [PERF_W-1:0] perf_if_cnt,
   output logic [PERF_W-1:0] perf_mem_cnt,
   output logic [PERF_W-1:0] perf_dbg_cnt
`endif
);

   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam int LW = $clog2(MAX_LOCK + 1);

   state_t        state_q, state_d;
   owner_t        owner_q, owner_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;

   // Handshake: a requester holds *_req and its operands until *_gnt is high in the
   // same cycle; read data follows one cycle later on rdata, qualified by its *_rvalid.
   always_comb begin
      if_gnt  = 1'b0;
      mem_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (!rst) begin
         case (state_q)
            S_ARB: begin
               if (dbg_req && (starve_cnt_q == SW'(STARVE_LIM))) dbg_gnt = 1'b1;
               else if (mem_req)                                  mem_gnt = 1'b1;
               else if (if_req)                                   if_gnt  = 1'b1;
               else if (dbg_req)                                  dbg_gnt = 1'b1;
            end
            S_LOCK: dbg_gnt = dbg_req;
            S_REL: begin
               if (mem_req)     mem_gnt = 1'b1;
               else if (if_req) if_gnt  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Lock owner keeps the port through the MAX_LOCK-th locked cycle, then is evicted.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      lock_err   = 1'b0;
      case (state_q)
         S_ARB: begin
            if (dbg_gnt && dbg_lock) begin
               state_d    = S_LOCK;
               lock_cnt_d = LW'(1);
            end
         end
         S_LOCK: begin
            if (!dbg_lock) begin
               state_d = S_REL;
            end else if (lock_cnt_q == LW'(MAX_LOCK)) begin
               lock_err = 1'b1;
               state_d  = S_REL;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
         S_REL: begin
            state_d    = S_ARB;
            lock_cnt_d = '0;
         end
         default: begin
            state_d    = S_ARB;
            lock_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (dbg_gnt || !dbg_req) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != SW'(STARVE_LIM)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_comb begin
      owner_d   = OWN_NONE;
      ram_we    = 1'b0;
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
      if (if_gnt) begin
         owner_d  = OWN_IF;
         ram_addr = if_addr;
      end else if (mem_gnt) begin
         owner_d = mem_we ? OWN_NONE : OWN_MEM;
         ram_we  = mem_we;
      end else if (dbg_gnt) begin
         owner_d   = dbg_we ? OWN_NONE : OWN_DBG;
         ram_we    = dbg_we;
         ram_addr  = dbg_addr;
         ram_wdata = dbg_wdata;
      end
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q      <= S_ARB;
         owner_q      <= OWN_NONE;
         starve_cnt_q <= '0;
         lock_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
      end
   end

   assign ram_en     = if_gnt | mem_gnt | dbg_gnt;
   assign if_stall   = if_req & ~if_gnt;
   assign mem_stall  = mem_req & ~mem_gnt;
   assign if_rvalid  = (owner_q == OWN_IF);
   assign mem_rvalid = (owner_q == OWN_MEM);
   assign dbg_rvalid = (owner_q == OWN_DBG);
   assign rdata      = ram_rdata;
   assign arb_state  = state_q;

`ifdef ARB_PERF_EN
   mips_arb_perf_ctr u_perf_if  (.clk1(clk1), .rst(rst), .clr_i(perf_clr), .inc_i(if_gnt),  .cnt_o(perf_if_cnt));
   mips_arb_perf_ctr u_perf_mem (.clk1(clk1), .rst(rst), .clr_i(perf_clr), .inc_i(mem_gnt), .cnt_o(perf_mem_cnt));
   mips_arb_perf_ctr u_perf_dbg (.clk1(clk1), .rst(rst), .clr_i(perf_clr), .inc_i(dbg_gnt), .cnt_o(perf_dbg_cnt));
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter with a write-first RAM model and read-data scoreboard.
// Exercises the perf counters too when ARB_PERF_EN is defined.
module tb_mips_mem_arbiter;
  import mips_arb_pkg::*;

  localparam logic [31:0] W0 = 32'h2801000a;
  localparam logic [31:0] W1 = 32'h28020014;
  localparam logic [31:0] W2 = 32'h28030019;
  localparam logic [31:0] M5 = 32'h24020005;
  localparam logic [31:0] M8 = 32'h28020014;

  // ---------------- clock / reset ----------------
  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  logic        if_req, mem_req, mem_we, dbg_req, dbg_we, dbg_lock;
  logic [9:0]  if_addr, mem_addr, dbg_addr, ram_addr;
  logic [31:0] mem_wdata, dbg_wdata, rdata, ram_wdata, ram_rdata;
  logic        if_gnt, if_stall, if_rvalid, mem_gnt, mem_stall, mem_rvalid;
  logic        dbg_gnt, dbg_rvalid, lock_err, ram_en, ram_we;
  logic [1:0]  arb_state;
`ifdef ARB_PERF_EN
  logic        perf_clr = 1'b0;
  logic [15:0] perf_if_cnt, perf_mem_cnt, perf_dbg_cnt;
`endif

  mips_mem_arbiter dut (
    .clk1(clk1), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall), .if_rvalid(if_rvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_stall(mem_stall), .mem_rvalid(mem_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .lock_err(lock_err),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .arb_state(arb_state)
`ifdef ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_if_cnt(perf_if_cnt), .perf_mem_cnt(perf_mem_cnt),
    .perf_dbg_cnt(perf_dbg_cnt)
`endif
  );

  // Write-first synchronous RAM, one cycle read latency.
  logic [31:0] ram_mem [0:1023];
  always @(posedge clk1) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_wdata;
        ram_rdata         <= ram_wdata;
      end else begin
        ram_rdata <= ram_mem[ram_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Entry = {if_rvalid, mem_rvalid, dbg_rvalid, rdata} expected the cycle after a read grant.
  logic [34:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    logic [34:0] e;
    logic [34:0] obs;
    @(posedge clk1);
    #1;
    obs = {if_rvalid, mem_rvalid, dbg_rvalid, rdata};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rd_sb: got rv=%b data=%h want rv=%b data=%h", obs[34:32], obs[31:0], e[34:32], e[31:0]);
      end
    end else if (obs[34:32] !== 3'b000) begin
      checks++;
      errors++;
      $display("FAIL rd_unexpected: got rv=%b want rv=000", obs[34:32]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic drive_if(input logic [9:0] a);
    if_req = 1'b1; if_addr = a;
  endtask

  task automatic drive_mem(input logic we, input logic [9:0] a, input logic [31:0] d);
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d;
  endtask

  task automatic drive_dbg(input logic we, input logic lk, input logic [9:0] a, input logic [31:0] d);
    dbg_req = 1'b1; dbg_we = we; dbg_lock = lk; dbg_addr = a; dbg_wdata = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    if_req = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    checks++;
    if ({if_gnt, mem_gnt, dbg_gnt, ram_en} !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt: got %b want 0000", {if_gnt, mem_gnt, dbg_gnt, ram_en});
    end
    checks++;
    if ({if_rvalid, mem_rvalid, dbg_rvalid, lock_err, arb_state} !== 6'b0) begin
      errors++; $display("FAIL reset_state: got %b want 000000", {if_rvalid, mem_rvalid, dbg_rvalid, lock_err, arb_state});
    end
    rst = 1'b0;
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle();
    drive_if(10'd5);
    drive_mem(1'b0, 10'd8, 32'h0);
    #1;
    checks++;
    if ({mem_gnt, if_gnt, if_stall, ram_addr} !== {3'b101, 10'd8}) begin
      errors++; $display("FAIL prio_c0: got mg=%b ig=%b is=%b a=%0d want 1 0 1 8", mem_gnt, if_gnt, if_stall, ram_addr);
    end
    exp_q.push_back({3'b010, M8});
    tick();
    mem_req = 1'b0;
    #1;
    checks++;
    if ({if_gnt, ram_addr} !== {1'b1, 10'd5}) begin
      errors++; $display("FAIL prio_c1: got ig=%b a=%0d want 1 5", if_gnt, ram_addr);
    end
    exp_q.push_back({3'b100, M5});
    tick();
    idle();
  endtask

  task automatic test_starve();
    drive_mem(1'b0, 10'd8, 32'h0);
    drive_if(10'd5);
    drive_dbg(1'b0, 1'b0, 10'd5, 32'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if ({mem_gnt, dbg_gnt} !== ((k == 4) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL starve_k%0d: got mg=%b dg=%b want %b", k, mem_gnt, dbg_gnt, (k == 4) ? 2'b01 : 2'b10);
      end
      exp_q.push_back((k == 4) ? {3'b001, M5} : {3'b010, M8});
      tick();
    end
    idle();
  endtask

  task automatic test_lock_load();
    logic [31:0] wv [3];
    wv[0] = W0; wv[1] = W1; wv[2] = W2;
    for (int k = 0; k < 3; k++) begin
      drive_dbg(1'b1, 1'b1, 10'(k), wv[k]);
      if (k > 0) drive_if(10'd0);
      #1;
      checks++;
      if ({dbg_gnt, if_stall, ram_we} !== {1'b1, (k > 0), 1'b1}) begin
        errors++; $display("FAIL lock_wr%0d: got dg=%b is=%b we=%b want 1 %b 1", k, dbg_gnt, if_stall, ram_we, k > 0);
      end
      tick();
    end
    dbg_req = 1'b0; dbg_lock = 1'b0;
    #1;
    checks++;
    if ({if_stall, dbg_gnt, arb_state} !== {2'b10, S_LOCK}) begin
      errors++; $display("FAIL lock_drop: got is=%b dg=%b st=%0d want 1 0 %0d", if_stall, dbg_gnt, arb_state, S_LOCK);
    end
    tick();
    dbg_req = 1'b1;
    #1;
    checks++;
    if ({arb_state, if_gnt, dbg_gnt} !== {S_REL, 2'b10}) begin
      errors++; $display("FAIL rel_bubble: got st=%0d ig=%b dg=%b want %0d 1 0", arb_state, if_gnt, dbg_gnt, S_REL);
    end
    exp_q.push_back({3'b100, W0});
    tick();
    idle();
    for (int k = 1; k < 3; k++) begin
      drive_dbg(1'b0, 1'b0, 10'(k), 32'h0);
      #1;
      checks++;
      if (dbg_gnt !== 1'b1) begin
        errors++; $display("FAIL dbg_rd%0d: got dg=%b want 1", k, dbg_gnt);
      end
      exp_q.push_back({3'b001, wv[k]});
      tick();
    end
    idle();
  endtask

  task automatic test_max_lock();
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) drive_dbg(1'b1, 1'b1, 10'(16 + k), 32'h1000 + k);
      else begin dbg_req = 1'b0; dbg_lock = 1'b0; end
      if (k >= 1) drive_mem(1'b0, 10'd8, 32'h0);
      #1;
      checks++;
      if (k <= 8) begin
        if ({dbg_gnt, mem_gnt, lock_err} !== {2'b10, (k == 8)}) begin
          errors++; $display("FAIL lock_k%0d: got dg=%b mg=%b le=%b want 1 0 %b", k, dbg_gnt, mem_gnt, lock_err, k == 8);
        end
      end else begin
        if ({dbg_gnt, mem_gnt, lock_err, arb_state} !== {3'b010, (k == 9) ? S_REL : S_ARB}) begin
          errors++; $display("FAIL unlock_k%0d: got dg=%b mg=%b le=%b st=%0d", k, dbg_gnt, mem_gnt, lock_err, arb_state);
        end
        exp_q.push_back({3'b010, M8});
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    drive_mem(1'b0, 10'd8, 32'h0);
    #1;
    checks++;
    if (mem_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_gnt: got %b want 1", mem_gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({if_gnt, mem_gnt, dbg_gnt, ram_en, lock_err, mem_rvalid} !== 6'b0) begin
      errors++; $display("FAIL rstmid_async: got %b want 000000", {if_gnt, mem_gnt, dbg_gnt, ram_en, lock_err, mem_rvalid});
    end
    @(posedge clk1);
    #1;
    checks++;
    if ({mem_rvalid, if_rvalid, dbg_rvalid, arb_state} !== 5'b0) begin
      errors++; $display("FAIL rstmid_rvalid: got %b want 00000", {mem_rvalid, if_rvalid, dbg_rvalid, arb_state});
    end
    idle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_raw();
    drive_mem(1'b1, 10'd40, 32'hdeadbeef);
    #1;
    checks++;
    if ({mem_gnt, ram_we, ram_wdata} !== {2'b11, 32'hdeadbeef}) begin
      errors++; $display("FAIL raw_wr: got mg=%b we=%b d=%h want 1 1 deadbeef", mem_gnt, ram_we, ram_wdata);
    end
    tick();
    drive_mem(1'b0, 10'd40, 32'h0);
    #1;
    exp_q.push_back({3'b010, 32'hdeadbeef});
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [31:0] tab [3];
    int r;
    int a;
    tab[0] = W0; tab[1] = W1; tab[2] = W2;
    for (int n = 0; n < 12; n++) begin
      idle();
      r = $urandom_range(0, 2);
      a = $urandom_range(0, 2);
      case (r)
        0:       drive_if(10'(a));
        1:       drive_mem(1'b0, 10'(a), 32'h0);
        default: drive_dbg(1'b0, 1'b0, 10'(a), 32'h0);
      endcase
      #1;
      checks++;
      if ({if_gnt, mem_gnt, dbg_gnt} !== (3'b100 >> r)) begin
        errors++; $display("FAIL rand_gnt%0d: got %b want %b", n, {if_gnt, mem_gnt, dbg_gnt}, 3'b100 >> r);
      end
      exp_q.push_back({3'b100 >> r, tab[a]});
      tick();
    end
    idle();
  endtask

`ifdef ARB_PERF_EN
  task automatic test_perf();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    for (int n = 0; n < 20; n++) begin
      drive_if(10'd0);
      #1;
      exp_q.push_back({3'b100, W0});
      tick();
    end
    idle();
    checks++;
    if (perf_if_cnt !== 16'd20) begin
      errors++; $display("FAIL perf_if20: got %0d want 20", perf_if_cnt);
    end
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive_dbg(1'b0, 1'b0, 10'd1, 32'h0);
      #1;
      exp_q.push_back({3'b001, W1});
      tick();
    end
    idle();
    checks++;
    if ({perf_if_cnt, perf_dbg_cnt, perf_mem_cnt} !== {16'd0, 16'd3, 16'd0}) begin
      errors++; $display("FAIL perf_clr: got if=%0d dbg=%0d mem=%0d want 0 3 0", perf_if_cnt, perf_dbg_cnt, perf_mem_cnt);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0;
    ram_mem[5] = M5;
    ram_mem[8] = M8;
    ram_rdata  = 32'h0;
    test_reset();
    test_same_cycle();
    test_starve();
    test_lock_load();
    test_max_lock();
    test_reset_mid();
    test_raw();
    test_random();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
